// File: rtl/dma_stream_writer.sv
// Stream-to-RAM DMA writer for the raw port of the dual-port DMA block RAM.
// Optional read-modify-write accumulate mode: define DMA_STREAM_WRITER_ACCUM_EN.
module dma_stream_writer #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [ADDR_WIDTH-1:0] cfg_base_i,
  input  logic [ADDR_WIDTH:0]   cfg_len_i,
  input  logic                  cfg_circular_i,
  input  logic [ADDR_WIDTH:0]   cfg_thresh_i,
  input  logic                  cfg_accum_i,
  input  logic                  cfg_start_i,
  input  logic                  cfg_stop_i,
  input  logic                  irq_ack_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  irq_o,
  output logic                  wrapped_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic [ADDR_WIDTH-1:0] rawp_adr_o,
  output logic [31:0]           rawp_dat_o,
  input  logic [31:0]           rawp_dat_i,
  output logic                  rawp_we_o,
  input  logic                  rawp_stall_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
`ifdef DMA_STREAM_WRITER_ACCUM_EN
  localparam logic [1:0] S_ACC_WR = 2'd2;
`endif
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH:0]   r_len;
  logic                  r_circ;
  logic [ADDR_WIDTH:0]   r_thresh;
  logic [ADDR_WIDTH-1:0] r_off;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_wrapped;
  logic                  r_irq;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [31:0]           r_dat;
  logic                  r_we;

  logic                  w_xfer;
  logic                  w_last;
  logic                  w_cnt_inc;
  logic [ADDR_WIDTH:0]   w_cnt_nx;
  logic                  w_commit;

`ifdef DMA_STREAM_WRITER_ACCUM_EN
  logic        r_accum;
  logic [31:0] r_hold;
  logic        r_acc_sum;
  logic        r_stop_pend;

  // A word is committed when written: on the RUN transfer for plain writes,
  // in ACC_WR for read-modify-write.
  assign w_commit   = (w_xfer && !r_accum) || (r_state == S_ACC_WR);
  // RAM read data only arrives in the write cycle, so the sum is formed there.
  assign rawp_dat_o = r_acc_sum ? (rawp_dat_i + r_hold) : r_dat;
`else
  logic w_unused;

  assign w_unused   = ^{cfg_accum_i, rawp_dat_i};
  assign w_commit   = w_xfer;
  assign rawp_dat_o = r_dat;
`endif

  assign s_ready_o  = (r_state == S_RUN) && !rawp_stall_i;
  assign w_xfer     = s_valid_i && s_ready_o;
  assign w_last     = ({1'b0, r_off} == (r_len - 1'b1));
  assign w_cnt_inc  = (r_count != r_len);
  assign w_cnt_nx   = r_count + 1'b1;

  assign busy_o     = (r_state == S_RUN)
`ifdef DMA_STREAM_WRITER_ACCUM_EN
                      || (r_state == S_ACC_WR)
`endif
                      ;
  assign done_o     = (r_state == S_DONE);
  assign irq_o      = r_irq;
  assign wrapped_o  = r_wrapped;
  assign count_o    = r_count;
  assign rawp_adr_o = r_adr;
  assign rawp_we_o  = r_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_len     <= '0;
      r_circ    <= 1'b0;
      r_thresh  <= '0;
      r_off     <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
      r_irq     <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_we      <= 1'b0;
`ifdef DMA_STREAM_WRITER_ACCUM_EN
      r_accum     <= 1'b0;
      r_hold      <= '0;
      r_acc_sum   <= 1'b0;
      r_stop_pend <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking throughout, so later assignments in this block
      // (state branches, commit, irq set) override the defaults below.
      r_we <= 1'b0;
`ifdef DMA_STREAM_WRITER_ACCUM_EN
      r_acc_sum <= 1'b0;
`endif
      if (irq_ack_i) r_irq <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (cfg_start_i) begin
            if (cfg_len_i == '0) begin
              r_state <= S_DONE;
            end else begin
              r_base    <= cfg_base_i;
              r_len     <= cfg_len_i;
              r_circ    <= cfg_circular_i;
              r_thresh  <= cfg_thresh_i;
              r_off     <= '0;
              r_count   <= '0;
              r_wrapped <= 1'b0;
              r_irq     <= 1'b0;
`ifdef DMA_STREAM_WRITER_ACCUM_EN
              r_accum   <= cfg_accum_i;
`endif
              r_state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            r_adr <= r_base + r_off;
            r_dat <= s_data_i;
`ifdef DMA_STREAM_WRITER_ACCUM_EN
            if (r_accum) begin
              r_hold      <= s_data_i;
              r_stop_pend <= cfg_stop_i;
            end else begin
              r_we <= 1'b1;
            end
`else
            r_we <= 1'b1;
`endif
          end
`ifdef DMA_STREAM_WRITER_ACCUM_EN
          if (w_xfer && r_accum) r_state <= S_ACC_WR;
          else
`endif
          if (cfg_stop_i || (w_xfer && w_last && !r_circ)) r_state <= S_DONE;
        end
`ifdef DMA_STREAM_WRITER_ACCUM_EN
        S_ACC_WR: begin
          r_we      <= 1'b1;
          r_acc_sum <= 1'b1;
          if (r_stop_pend || cfg_stop_i || (w_last && !r_circ)) r_state <= S_DONE;
          else r_state <= S_RUN;
        end
`endif
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_commit) begin
        // Only a real increment can make count reach thresh, so a saturated
        // count never re-raises an acknowledged interrupt.
        if (w_cnt_inc) begin
          r_count <= w_cnt_nx;
          if (w_cnt_nx == r_thresh) r_irq <= 1'b1;
        end
        if (w_last) begin
          r_off <= '0;
          if (r_circ) r_wrapped <= 1'b1;
        end else begin
          r_off <= r_off + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_stream_writer.sv
// Directed bench for dma_stream_writer: per-cycle vector table plus sequences
// for interrupt, reset abort, zero length and (when enabled) accumulate.
module tb_dma_stream_writer;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   s_data_i = '0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic [AW-1:0] cfg_base_i = '0;
  logic [AW:0]   cfg_len_i = '0;
  logic          cfg_circular_i = 1'b0;
  logic [AW:0]   cfg_thresh_i = '0;
  logic          cfg_accum_i = 1'b0;
  logic          cfg_start_i = 1'b0;
  logic          cfg_stop_i = 1'b0;
  logic          irq_ack_i = 1'b0;
  logic          busy_o, done_o, irq_o, wrapped_o;
  logic [AW:0]   count_o;
  logic [AW-1:0] rawp_adr_o;
  logic [31:0]   rawp_dat_o;
  logic [31:0]   rawp_dat_i;
  logic          rawp_we_o;
  logic          rawp_stall_i = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dma_stream_writer #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .cfg_base_i(cfg_base_i), .cfg_len_i(cfg_len_i),
    .cfg_circular_i(cfg_circular_i), .cfg_thresh_i(cfg_thresh_i),
    .cfg_accum_i(cfg_accum_i), .cfg_start_i(cfg_start_i),
    .cfg_stop_i(cfg_stop_i), .irq_ack_i(irq_ack_i),
    .busy_o(busy_o), .done_o(done_o), .irq_o(irq_o), .wrapped_o(wrapped_o),
    .count_o(count_o), .rawp_adr_o(rawp_adr_o), .rawp_dat_o(rawp_dat_o),
    .rawp_dat_i(rawp_dat_i), .rawp_we_o(rawp_we_o), .rawp_stall_i(rawp_stall_i)
  );

  // RAM raw port: synchronous write, read data one cycle after the address.
  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] ram_rd;
  assign rawp_dat_i = ram_rd;
  always @(posedge clk) begin
    if (rst) begin
      mem[9'h020] <= 32'd5;
      mem[9'h021] <= 32'd100;
    end else if (rawp_we_o) begin
      mem[rawp_adr_o] <= rawp_dat_o;
    end
    ram_rd <= mem[rawp_adr_o];
  end

  typedef struct {
    logic          vld;
    logic [31:0]   data;
    logic          stall;
    logic          stop;
    logic          rdy;
    logic          we;
    logic [AW-1:0] adr;
    logic [31:0]   dat;
    logic          busy;
    logic          done;
    logic [AW:0]   cnt;
    logic          wrap;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic vld, input logic [31:0] data,
                              input logic stall, input logic stop,
                              input logic rdy, input logic we,
                              input logic [AW-1:0] adr, input logic [31:0] dat,
                              input logic busy, input logic done,
                              input logic [AW:0] cnt, input logic wrap);
    vec_t v;
    v = '{vld, data, stall, stop, rdy, we, adr, dat, busy, done, cnt, wrap};
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cfg(input logic [AW-1:0] base, input logic [AW:0] len,
                           input logic circ, input logic [AW:0] thresh,
                           input logic accum);
    cfg_base_i     = base;
    cfg_len_i      = len;
    cfg_circular_i = circ;
    cfg_thresh_i   = thresh;
    cfg_accum_i    = accum;
    cfg_start_i    = 1'b1;
    tick();
    cfg_start_i    = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      s_valid_i    = vecs[i].vld;
      s_data_i     = vecs[i].data;
      rawp_stall_i = vecs[i].stall;
      cfg_stop_i   = vecs[i].stop;
      #1;
      check($sformatf("v%0d_ready", i), s_ready_o, vecs[i].rdy);
      tick();
      check($sformatf("v%0d_we", i), rawp_we_o, vecs[i].we);
      if (vecs[i].we) begin
        check($sformatf("v%0d_adr", i), rawp_adr_o, vecs[i].adr);
        check($sformatf("v%0d_dat", i), rawp_dat_o, vecs[i].dat);
      end
      check($sformatf("v%0d_busy", i), busy_o, vecs[i].busy);
      check($sformatf("v%0d_done", i), done_o, vecs[i].done);
      check($sformatf("v%0d_count", i), count_o, vecs[i].cnt);
      check($sformatf("v%0d_wrapped", i), wrapped_o, vecs[i].wrap);
    end
    s_valid_i    = 1'b0;
    rawp_stall_i = 1'b0;
    cfg_stop_i   = 1'b0;
  endtask

  initial begin
    // Rows 0..5: single-shot, base 0x10, len 4.
    add(1, 32'hA0, 0, 0, 1, 1, 9'h010, 32'hA0, 1, 0, 1, 0);
    add(1, 32'hA1, 0, 0, 1, 1, 9'h011, 32'hA1, 1, 0, 2, 0);
    add(1, 32'hA2, 0, 0, 1, 1, 9'h012, 32'hA2, 1, 0, 3, 0);
    add(1, 32'hA3, 0, 0, 1, 1, 9'h013, 32'hA3, 0, 1, 4, 0);
    add(1, 32'hA4, 0, 0, 0, 0, 9'h000, 32'h00, 0, 0, 4, 0);
    add(1, 32'hA5, 0, 0, 0, 0, 9'h000, 32'h00, 0, 0, 4, 0);
    // Rows 6..19: circular across the top of RAM, stall, stop with transfer.
    add(1, 32'hB0, 0, 0, 1, 1, 9'h1FE, 32'hB0, 1, 0, 1, 0);
    add(1, 32'hB1, 0, 0, 1, 1, 9'h1FF, 32'hB1, 1, 0, 2, 0);
    add(1, 32'hB2, 0, 0, 1, 1, 9'h000, 32'hB2, 1, 0, 3, 0);
    add(1, 32'hB3, 0, 0, 1, 1, 9'h001, 32'hB3, 1, 0, 4, 1);
    add(1, 32'hB4, 0, 0, 1, 1, 9'h1FE, 32'hB4, 1, 0, 4, 1);
    add(1, 32'hB5, 0, 0, 1, 1, 9'h1FF, 32'hB5, 1, 0, 4, 1);
    add(1, 32'hC0, 0, 0, 1, 1, 9'h000, 32'hC0, 1, 0, 4, 1);
    add(1, 32'hC1, 1, 0, 0, 0, 9'h000, 32'h00, 1, 0, 4, 1);
    add(1, 32'hC1, 1, 0, 0, 0, 9'h000, 32'h00, 1, 0, 4, 1);
    add(1, 32'hC1, 1, 0, 0, 0, 9'h000, 32'h00, 1, 0, 4, 1);
    add(1, 32'hC1, 0, 0, 1, 1, 9'h001, 32'hC1, 1, 0, 4, 1);
    add(1, 32'hC2, 0, 0, 1, 1, 9'h1FE, 32'hC2, 1, 0, 4, 1);
    add(1, 32'hD0, 0, 1, 1, 1, 9'h1FF, 32'hD0, 0, 1, 4, 1);
    add(1, 32'hE0, 0, 0, 0, 0, 9'h000, 32'h00, 0, 0, 4, 1);

    // Reset state.
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_irq", irq_o, 1'b0);
    check("rst_wrapped", wrapped_o, 1'b0);
    check("rst_count", count_o, '0);
    check("rst_we", rawp_we_o, 1'b0);
    check("rst_adr", rawp_adr_o, '0);
    check("rst_dat", rawp_dat_o, '0);
    check("rst_ready", s_ready_o, 1'b0);

    start_cfg(9'h010, 10'd4, 1'b0, 10'd0, 1'b0);
    run_vecs(0, 5);

    start_cfg(9'h1FE, 10'd4, 1'b1, 10'd0, 1'b0);
    run_vecs(6, 19);
    check("circ_irq_thresh0", irq_o, 1'b0);

    // Interrupt at thresh 3, set beats ack, start while busy ignored.
    start_cfg(9'h000, 10'd8, 1'b0, 10'd3, 1'b0);
    s_valid_i = 1'b1; s_data_i = 32'd1;
    tick();
    check("irq_c1_count", count_o, 10'd1);
    check("irq_c1_irq", irq_o, 1'b0);
    s_data_i = 32'd2;
    tick();
    check("irq_c2_irq", irq_o, 1'b0);
    s_data_i = 32'd3; irq_ack_i = 1'b1; cfg_start_i = 1'b1; cfg_base_i = 9'h100;
    tick();
    check("irq_c3_count", count_o, 10'd3);
    check("irq_set_beats_ack", irq_o, 1'b1);
    check("start_busy_ignored_adr", rawp_adr_o, 9'h002);
    s_valid_i = 1'b0; irq_ack_i = 1'b0; cfg_start_i = 1'b0;
    tick();
    check("irq_sticky", irq_o, 1'b1);
    check("idle_cycle_we", rawp_we_o, 1'b0);
    irq_ack_i = 1'b1;
    tick();
    check("irq_ack_clears", irq_o, 1'b0);
    irq_ack_i = 1'b0; s_valid_i = 1'b1; s_data_i = 32'd4;
    tick();
    check("irq_c4_count", count_o, 10'd4);
    check("irq_c4_adr", rawp_adr_o, 9'h003);
    check("irq_no_reset_after_thresh", irq_o, 1'b0);

    // Synchronous reset with a concurrent transfer aborts the run.
    s_data_i = 32'd5; rst = 1'b1;
    tick();
    check("abort_we", rawp_we_o, 1'b0);
    check("abort_busy", busy_o, 1'b0);
    check("abort_done", done_o, 1'b0);
    check("abort_count", count_o, '0);
    check("abort_adr", rawp_adr_o, '0);
    check("abort_dat", rawp_dat_o, '0);
    rst = 1'b0; s_valid_i = 1'b0;
    tick();
    check("abort_no_done", done_o, 1'b0);
    check("abort_idle_busy", busy_o, 1'b0);

    // Zero-length start goes straight to DONE.
    start_cfg(9'h005, 10'd0, 1'b0, 10'd0, 1'b0);
    check("len0_done", done_o, 1'b1);
    check("len0_busy", busy_o, 1'b0);
    tick();
    check("len0_done_once", done_o, 1'b0);

`ifdef DMA_STREAM_WRITER_ACCUM_EN
    // Accumulate: RAM[0x20]=5 + 7 -> 12, RAM[0x21]=100 + 3 -> 103.
    start_cfg(9'h020, 10'd2, 1'b0, 10'd0, 1'b1);
    s_valid_i = 1'b1; s_data_i = 32'd7;
    #1;
    check("acc_ready0", s_ready_o, 1'b1);
    tick();
    check("acc_rd0_we", rawp_we_o, 1'b0);
    check("acc_rd0_adr", rawp_adr_o, 9'h020);
    check("acc_rd0_ready", s_ready_o, 1'b0);
    check("acc_rd0_busy", busy_o, 1'b1);
    s_data_i = 32'd3;
    tick();
    check("acc_wr0_we", rawp_we_o, 1'b1);
    check("acc_wr0_adr", rawp_adr_o, 9'h020);
    check("acc_wr0_dat", rawp_dat_o, 32'd12);
    check("acc_wr0_ready", s_ready_o, 1'b1);
    tick();
    check("acc_rd1_we", rawp_we_o, 1'b0);
    check("acc_rd1_adr", rawp_adr_o, 9'h021);
    check("acc_rd1_ready", s_ready_o, 1'b0);
    s_valid_i = 1'b0;
    tick();
    check("acc_wr1_we", rawp_we_o, 1'b1);
    check("acc_wr1_dat", rawp_dat_o, 32'd103);
    check("acc_wr1_done", done_o, 1'b1);
    check("acc_wr1_count", count_o, 10'd2);
`else
    // Without accumulate support the accum config bit is ignored.
    start_cfg(9'h020, 10'd1, 1'b0, 10'd0, 1'b1);
    s_valid_i = 1'b1; s_data_i = 32'd7;
    tick();
    s_valid_i = 1'b0;
    check("noacc_we", rawp_we_o, 1'b1);
    check("noacc_dat", rawp_dat_o, 32'd7);
    check("noacc_done", done_o, 1'b1);
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
